// File: rtl/twos_complement.sv
// Nibble negator: R = (~A + 1) mod 16, plus ovf (A == -8) and zero flags. Latency is 1 cycle with
// REG_OUT=1 and 0 cycles with REG_OUT=0. There is no backpressure: one operand per cycle, in_valid only qualifies.
module twos_complement #(
    parameter bit REG_OUT = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic in1,
    input  logic in2,
    input  logic in3,
    input  logic in4,
    input  logic in_valid,
    output logic out1,
    output logic out2,
    output logic out3,
    output logic out4,
    output logic out_valid,
    output logic ovf,
    output logic zero
);

    logic [3:0] a_dat;
    logic [3:0] neg_dat;
    logic       neg_ovf;
    logic       neg_zero;

    logic [3:0] r_d, r_q;
    logic       ovf_d, ovf_q;
    logic       zero_d, zero_q;
    logic       vld_d, vld_q;

    // The carry out of bit 3 is dropped, so -8 negates to itself and gets flagged.
    always_comb begin
        a_dat    = {in1, in2, in3, in4};
        neg_dat  = ~a_dat + 4'd1;
        neg_ovf  = (a_dat == 4'b1000);
        neg_zero = (a_dat == 4'b0000);
    end

    always_comb begin
        r_d    = r_q;
        ovf_d  = ovf_q;
        zero_d = zero_q;
        vld_d  = 1'b0;
        if (rst) begin
            r_d    = 4'b0000;
            ovf_d  = 1'b0;
            zero_d = 1'b0;
        end else if (in_valid) begin
            r_d    = neg_dat;
            ovf_d  = neg_ovf;
            zero_d = neg_zero;
            vld_d  = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        r_q    <= r_d;
        ovf_q  <= ovf_d;
        zero_q <= zero_d;
        vld_q  <= vld_d;
    end

    // In the combinational build the flops are left unread and get trimmed.
    always_comb begin
        if (REG_OUT) begin
            {out1, out2, out3, out4} = r_q;
            ovf                      = ovf_q;
            zero                     = zero_q;
            out_valid                = vld_q;
        end else begin
            {out1, out2, out3, out4} = neg_dat;
            ovf                      = neg_ovf;
            zero                     = neg_zero;
            out_valid                = in_valid & ~rst;
        end
    end

endmodule

// File: tb/tb_twos_complement.sv
// Checks the registered build, the combinational build and a two-stage chain against a reference model.
module tb_twos_complement;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic in1 = 1'b0, in2 = 1'b0, in3 = 1'b0, in4 = 1'b0;
    logic in_valid = 1'b0;

    logic r1, r2, r3, r4, r_vld, r_ovf, r_zero;
    logic c1, c2, c3, c4, c_vld, c_ovf, c_zero;
    logic i1, i2, i3, i4, i_vld, i_ovf, i_zero;

    int n_vec = 0;
    int n_err = 0;

    // Reference state for the registered build.
    int   m_r    = 0;
    logic m_ovf  = 1'b0;
    logic m_zero = 1'b0;
    logic m_vld  = 1'b0;

    always #5 clk = ~clk;

    twos_complement #(.REG_OUT(1'b1)) dut_reg (
        .clk(clk), .rst(rst),
        .in1(in1), .in2(in2), .in3(in3), .in4(in4), .in_valid(in_valid),
        .out1(r1), .out2(r2), .out3(r3), .out4(r4),
        .out_valid(r_vld), .ovf(r_ovf), .zero(r_zero)
    );

    twos_complement #(.REG_OUT(1'b0)) dut_cmb (
        .clk(clk), .rst(rst),
        .in1(in1), .in2(in2), .in3(in3), .in4(in4), .in_valid(in_valid),
        .out1(c1), .out2(c2), .out3(c3), .out4(c4),
        .out_valid(c_vld), .ovf(c_ovf), .zero(c_zero)
    );

    twos_complement #(.REG_OUT(1'b0)) dut_inv (
        .clk(clk), .rst(rst),
        .in1(c1), .in2(c2), .in3(c3), .in4(c4), .in_valid(c_vld),
        .out1(i1), .out2(i2), .out3(i3), .out4(i4),
        .out_valid(i_vld), .ovf(i_ovf), .zero(i_zero)
    );

    function automatic int negate(input int a);
        return (16 - a) % 16;
    endfunction

    task automatic chk(input string tag, input int obs, input int exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Drive one operand, check the combinational paths mid-cycle, then the registered result after the edge.
    task automatic apply(input int a, input logic v, input logic r);
        logic [3:0] av;
        av = 4'(a);
        {in1, in2, in3, in4} = av;
        in_valid = v;
        rst = r;
        @(negedge clk);
        chk("cmb_r",    int'({c1, c2, c3, c4}), negate(a));
        chk("cmb_ovf",  int'(c_ovf),  int'(a == 8));
        chk("cmb_zero", int'(c_zero), int'(a == 0));
        chk("cmb_vld",  int'(c_vld),  int'(v && !r));
        chk("invol",    int'({i1, i2, i3, i4}), a);
        @(posedge clk);
        if (r) begin
            m_r = 0; m_ovf = 1'b0; m_zero = 1'b0; m_vld = 1'b0;
        end else if (v) begin
            m_r = negate(a); m_ovf = (a == 8); m_zero = (a == 0); m_vld = 1'b1;
        end else begin
            m_vld = 1'b0;
        end
        #1;
        chk("reg_r",    int'({r1, r2, r3, r4}), m_r);
        chk("reg_ovf",  int'(r_ovf),  int'(m_ovf));
        chk("reg_zero", int'(r_zero), int'(m_zero));
        chk("reg_vld",  int'(r_vld),  int'(m_vld));
    endtask

    initial begin
        // Reset state
        apply(5, 1'b1, 1'b1);
        apply(9, 1'b0, 1'b1);

        // Exhaustive sweep, one operand per cycle
        for (int a = 0; a < 16; a++) apply(a, 1'b1, 1'b0);

        // Boundary codes with literal expectations
        apply(0, 1'b1, 1'b0);
        chk("bnd0_r", int'({r1, r2, r3, r4}), 0);
        chk("bnd0_zero", int'(r_zero), 1);
        apply(8, 1'b1, 1'b0);
        chk("bnd8_r", int'({r1, r2, r3, r4}), 8);
        chk("bnd8_ovf", int'(r_ovf), 1);
        apply(15, 1'b1, 1'b0);
        chk("bnd15_r", int'({r1, r2, r3, r4}), 1);

        // Mid-stream reset takes priority, result returns one cycle after release
        apply(3, 1'b1, 1'b1);
        chk("rst_r", int'({r1, r2, r3, r4}), 0);
        apply(3, 1'b1, 1'b0);
        chk("rst_next", int'({r1, r2, r3, r4}), 13);

        // Hold while in_valid is low
        apply(2, 1'b1, 1'b0);
        for (int k = 0; k < 3; k++) begin
            apply(6, 1'b0, 1'b0);
            chk("hold_r", int'({r1, r2, r3, r4}), 14);
        end
        apply(6, 1'b1, 1'b0);
        chk("hold_rel", int'({r1, r2, r3, r4}), 10);

        // Random operands, valids and occasional resets
        for (int k = 0; k < 200; k++) begin
            apply(int'($urandom_range(15, 0)),
                  logic'($urandom_range(3, 0) != 0),
                  logic'($urandom_range(15, 0) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
